// File: rtl/vec_pkg.sv
// Shared widths and types for the vector lane packer.
// Lane k of a vector occupies bits [k*N +: N].
package vec_pkg;

  localparam int V     = 128;
  localparam int N     = 32;
  localparam int LANES = V / N;
  localparam int CNT_W = $clog2(LANES);

  typedef enum logic {FILL, HOLD} packer_state_t;

  typedef logic [N-1:0] scalar_t;
  typedef logic [V-1:0] vector_t;

endpackage

// File: rtl/vector_lane_packer.sv
// Packs N-bit scalar beats into a V-bit vector, lane 0 first; in_last closes a short vector.
// Latency: out_valid rises the cycle after the final beat; out_data/out_mask come straight from registers.
// Backpressure: vector held until out_ready; in_ready low in HOLD unless PACKER_SKID_EN adds a one-beat skid.
module vector_lane_packer
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [V-1:0]     out_data,
  output logic [LANES-1:0] out_mask
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

  packer_state_t    state;
  logic [CNT_W-1:0] cnt;
  vector_t          buf_q;
  logic [LANES-1:0] mask_q;

  assign out_valid = (state == HOLD);
  assign out_data  = buf_q;
  assign out_mask  = mask_q;

`ifdef PACKER_SKID_EN
  scalar_t skid_data;
  logic    skid_last;
  logic    skid_full;

  assign in_ready = (state == FILL) || !skid_full;
`else
  assign in_ready = (state == FILL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL;
      cnt    <= '0;
      buf_q  <= '0;
      mask_q <= '0;
`ifdef PACKER_SKID_EN
      skid_data <= '0;
      skid_last <= 1'b0;
      skid_full <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            buf_q[cnt*N +: N] <= in_data;
            mask_q[cnt]       <= 1'b1;
            if (cnt == CNT_LAST || in_last) begin
              state <= HOLD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
`ifdef PACKER_SKID_EN
          if (out_ready) begin
            // A parked beat (or one arriving now) seeds lane 0 of the next vector.
            if (skid_full) begin
              buf_q     <= {{(V-N){1'b0}}, skid_data};
              mask_q    <= LANES'(1);
              skid_full <= 1'b0;
              state     <= skid_last ? HOLD : FILL;
              cnt       <= skid_last ? '0 : CNT_W'(1);
            end else if (in_valid) begin
              buf_q  <= {{(V-N){1'b0}}, in_data};
              mask_q <= LANES'(1);
              state  <= in_last ? HOLD : FILL;
              cnt    <= in_last ? '0 : CNT_W'(1);
            end else begin
              buf_q  <= '0;
              mask_q <= '0;
              state  <= FILL;
              cnt    <= '0;
            end
          end else if (in_valid && !skid_full) begin
            skid_data <= in_data;
            skid_last <= in_last;
            skid_full <= 1'b1;
          end
`else
          if (out_ready) begin
            buf_q  <= '0;
            mask_q <= '0;
            state  <= FILL;
            cnt    <= '0;
          end
`endif
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/vector_lane_packer.md
Name: vector_lane_packer

Overview:
- Sequential packer that gathers a stream of N-bit scalars (valid/ready) into one V-bit vector, lane by lane.
- Emits the completed vector with a lane mask over a valid/ready handshake.
- Sits upstream of the vector register write path.
- Lane numbering is fixed: lane k occupies bits [k*N+N-1 : k*N], so lane 0 is the least-significant slice.

Parameters:
- V, 128, vector width in bits.
- N, 32, scalar/lane width in bits.
- LANES, V/N (4), number of lanes; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  scalar beat is valid.
- in_ready  out  1  packer accepts the beat this cycle.
- in_data  in  N  scalar value.
- in_last  in  1  final beat of a short vector; closes the vector early.
- out_valid  out  1  packed vector available.
- out_ready  in  1  consumer takes the vector this cycle.
- out_data  out  V  packed vector.
- out_mask  out  LANES  bit k=1 when lane k was written.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=FILL, lane counter cnt=0, data buffer=0, mask=0.
  - out_valid=0, out_data=0, out_mask=0; in_ready=1 once rst_n deasserts.
- Beat acceptance: a beat is accepted when in_valid && in_ready at a clock edge. A transfer is out_valid && out_ready.
- State FILL:
  - in_ready=1, out_valid=0.
  - On acceptance: buffer lane cnt <= in_data; mask[cnt] <= 1.
  - If cnt==LANES-1 or in_last=1: go to HOLD, cnt <= 0. Otherwise cnt <= cnt+1.
  - in_last on lane LANES-1 behaves the same as a normal full vector.
- State HOLD:
  - out_valid=1; out_data and out_mask are stable until the transfer.
  - On transfer: go to FILL, buffer <= 0, mask <= 0.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Unwritten lanes of a short vector read as 0.
- Base throughput: LANES beats per LANES+1 cycles with out_ready held at 1.
- out_data is driven only from registers; no combinational path from in_data.
- cnt is ceil(log2(LANES)) bits wide and never wraps past LANES-1.
- in_last with in_valid=0 is ignored.
- A mid-operation reset discards the partial vector and the held vector; no output is produced for them.
- An out_ready pulse while out_valid=0 has no effect.

Optional Feature:
- Macro: PACKER_SKID_EN.
- Defined:
  - One-entry skid register {data, last, full}.
  - In HOLD, in_ready = !skid_full, so a beat accepted during HOLD lands in the skid.
  - On transfer with the skid full: the skid beat becomes lane 0 of the next vector, mask=0001, cnt=1, skid cleared.
  - If that skid beat had last=1, the next state is HOLD again; otherwise FILL.
  - Simultaneous transfer and new beat acceptance with the skid empty: the beat writes lane 0 of the next vector directly.
  - Result: one beat per cycle is sustained.
  - Reset clears skid_full.
- Undefined: in_ready=0 throughout HOLD; no skid logic is present.

Decomposition:
- Shared package vec_pkg holds:
  - localparams V=128, N=32, LANES=V/N, CNT_W=$clog2(LANES).
  - typedef enum logic {FILL, HOLD} packer_state_t.
  - typedef logic [N-1:0] scalar_t and logic [V-1:0] vector_t.
- No sub-module: the lane write is an indexed part-select inside the block.

Test Plan:
- Full vector: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 with out_ready=1.
  - Expect out_data=0x44444444_33333333_22222222_11111111 and out_mask=1111.
  - out_valid is high exactly one cycle, the cycle after beat 4.
- Short vector: beats 0xAAAA0001, 0xAAAA0002 with in_last on the second.
  - Expect out_data=0x0…0_AAAA0002_AAAA0001 and out_mask=0011.
- Backpressure: out_ready=0 for 5 cycles after completion.
  - out_data and out_mask stay constant; in_ready=0 (base build).
  - Transfer occurs on the cycle out_ready rises.
- Reset mid-fill: after 2 beats, pulse rst_n low asynchronously between edges.
  - Outputs go 0 immediately.
  - The next 4 beats 0x1…0x4 produce a clean vector, mask=1111.
- PACKER_SKID_EN streaming: 12 back-to-back beats 1..12 with out_ready=1.
  - Expect 3 vectors in consecutive 4-cycle windows, no input stall cycles.
  - Third vector is 0x0000000C_0000000B_0000000A_00000009.
- Single-beat in_last: one beat 0xDEADBEEF with in_last=1.
  - Expect out_mask=0001 and upper 96 bits zero.
